univ_shift_reg: RTL and testbench

- Parametrised universal shift register: hold, serial shift left/right, rotate, arithmetic shift, parallel load, clear.
- Counts serial shifts and pulses a word-complete flag every WIDTH shifts, so it can act as a serial deserializer.
- Drives a 7-segment hex display of a selectable nibble of the stored word.
- Sits between board switches (SWI) and LED/SEG outputs in top-level lab designs.

---
 rtl/univ_shift_reg_if.sv | 29 ++
 rtl/univ_shift_reg.sv | 131 +++++++++++++
 tb/tb_univ_shift_reg.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// Bundle of data/control signals between the lab top level and univ_shift_reg.
// master drives operation requests; slave (the register) returns its state and display.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic             ser_in;
    logic [WIDTH-1:0] par_in;
    logic [2:0]       nib_sel;
    logic [WIDTH-1:0] q;
    logic             ser_out_lsb;
    logic             ser_out_msb;
    logic [CNTW-1:0]  shift_cnt;
    logic             word_done;
    logic [7:0]       seg;

    modport master (
        output en, mode, ser_in, par_in, nib_sel,
        input  q, ser_out_lsb, ser_out_msb, shift_cnt, word_done, seg
    );

    modport slave (
        input  en, mode, ser_in, par_in, nib_sel,
        output q, ser_out_lsb, ser_out_msb, shift_cnt, word_done, seg
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register with serial-word counter and 7-segment nibble display.
// Serial shifts (SHR/SHL) are counted; word_done pulses when a full word has arrived.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1),
    parameter int NNIB  = (WIDTH + 3) / 4
) (
    input  logic            clk_2,
    input  logic            reset,
    univ_shift_reg_if.slave bus
);
    localparam int PADW = NNIB * 4;

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHR   = 3'b001,
        M_SHL   = 3'b010,
        M_ROR   = 3'b011,
        M_ROL   = 3'b100,
        M_LOAD  = 3'b101,
        M_CLEAR = 3'b110,
        M_ASR   = 3'b111
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [CNTW-1:0]  shift_cnt;
    logic             word_done;
    logic             serial;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        q_next = q;
        serial = 1'b0;
        case (mode)
            M_HOLD:  q_next = q;
            M_SHR: begin
                q_next = {bus.ser_in, q[WIDTH-1:1]};
                serial = 1'b1;
            end
            M_SHL: begin
                q_next = {q[WIDTH-2:0], bus.ser_in};
                serial = 1'b1;
            end
            M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            M_LOAD:  q_next = bus.par_in;
            M_CLEAR: q_next = '0;
            M_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

    // NOTE: reset is tested inside the clocked branch (synchronous), and all state uses
    // non-blocking assignments so each register samples pre-edge values.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            q         <= '0;
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else if (!bus.en) begin
            word_done <= 1'b0;
        end else begin
            q <= q_next;
            if (serial) begin
                if (shift_cnt == CNTW'(WIDTH - 1)) begin
                    shift_cnt <= '0;
                    word_done <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + CNTW'(1);
                    word_done <= 1'b0;
                end
            end else begin
                word_done <= 1'b0;
                if (mode == M_LOAD || mode == M_CLEAR) shift_cnt <= '0;
            end
        end
    end

    // Display path: zero-extend q to whole nibbles so a partial top nibble reads as 0.
    logic [PADW-1:0] padded;
    logic [3:0]      nib;
    logic            blank;
    logic [7:0]      seg;

    always_comb begin
        padded            = '0;
        padded[WIDTH-1:0] = q;
        nib               = 4'h0;
        blank             = 1'b1;
        for (int n = 0; n < NNIB; n++) begin
            if (bus.nib_sel == 3'(n)) begin
                nib   = padded[4*n +: 4];
                blank = 1'b0;
            end
        end
    end

    always_comb begin
        case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
            default: seg = 8'h00;
        endcase
        if (blank) seg = 8'h00;
    end

    assign bus.q           = q;
    assign bus.ser_out_lsb = q[0];
    assign bus.ser_out_msb = q[WIDTH-1];
    assign bus.shift_cnt   = shift_cnt;
    assign bus.word_done   = word_done;
    assign bus.seg         = seg;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model for WIDTH=8 checked every cycle,
// directed literal checks, and small directed runs on WIDTH=4 and WIDTH=12 builds.
module tb_univ_shift_reg;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam bit [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic clk_2 = 1'b0;
    logic reset;
    always #5 clk_2 = ~clk_2;

    univ_shift_reg_if #(.WIDTH(8))  b8 ();
    univ_shift_reg_if #(.WIDTH(4))  b4 ();
    univ_shift_reg_if #(.WIDTH(12)) b12 ();

    univ_shift_reg #(.WIDTH(8))  dut8  (.clk_2(clk_2), .reset(reset), .bus(b8.slave));
    univ_shift_reg #(.WIDTH(4))  dut4  (.clk_2(clk_2), .reset(reset), .bus(b4.slave));
    univ_shift_reg #(.WIDTH(12)) dut12 (.clk_2(clk_2), .reset(reset), .bus(b12.slave));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int seg_of(input int v, input int sel, input int w);
        if (sel >= (w + 3) / 4) return 0;
        return int'(HEX[(v >> (4 * sel)) & 15]);
    endfunction

    // Reference model: word value as an integer, counter as shifts into the current word.
    int mq, mcnt;
    bit mdone;
    always @(posedge clk_2) begin
        if (reset) begin
            mq = 0; mcnt = 0; mdone = 0;
        end else if (!b8.en) begin
            mdone = 0;
        end else begin
            case (b8.mode)
                3'd1: mq = (mq >> 1) | (int'(b8.ser_in) << (W - 1));
                3'd2: mq = ((mq << 1) | int'(b8.ser_in)) & MASK;
                3'd3: mq = (mq >> 1) | ((mq & 1) << (W - 1));
                3'd4: mq = ((mq << 1) | (mq >> (W - 1))) & MASK;
                3'd5: mq = int'(b8.par_in);
                3'd6: mq = 0;
                3'd7: mq = (mq >> 1) | (mq & (1 << (W - 1)));
                default: ;
            endcase
            if (b8.mode == 3'd1 || b8.mode == 3'd2) begin
                mcnt  = mcnt + 1;
                mdone = (mcnt == W);
                if (mdone) mcnt = 0;
            end else begin
                mdone = 0;
                if (b8.mode == 3'd5 || b8.mode == 3'd6) mcnt = 0;
            end
        end
    end

    always @(negedge clk_2) begin
        if (chk_en) begin
            check("m_q",    32'(b8.q),           32'(mq));
            check("m_cnt",  32'(b8.shift_cnt),   32'(mcnt));
            check("m_done", 32'(b8.word_done),   32'(mdone));
            check("m_lsb",  32'(b8.ser_out_lsb), 32'(mq & 1));
            check("m_msb",  32'(b8.ser_out_msb), 32'((mq >> (W - 1)) & 1));
            check("m_seg",  32'(b8.seg),         32'(seg_of(mq, int'(b8.nib_sel), W)));
        end
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic s, input logic [7:0] p);
        reset     = r;
        b8.en     = e;
        b8.mode   = m;
        b8.ser_in = s;
        b8.par_in = p;
        tick();
    endtask

    localparam logic [7:0] SER_SEQ = 8'b0100_1101;

    initial begin
        b8.nib_sel = 3'd0;
        b4.en = 1'b0;  b4.mode = 3'd0;  b4.ser_in = 1'b0;  b4.par_in = '0;  b4.nib_sel = 3'd0;
        b12.en = 1'b0; b12.mode = 3'd0; b12.ser_in = 1'b0; b12.par_in = '0; b12.nib_sel = 3'd0;

        // Reset and blanking
        cyc(1, 1, 3'd2, 1, 8'hFF);
        chk_en = 1'b1;
        cyc(1, 1, 3'd2, 1, 8'hFF);
        cyc(0, 1, 3'd0, 0, 8'h00);
        check("rst_q", 32'(b8.q), 32'h00);
        check("rst_cnt", 32'(b8.shift_cnt), 0);
        check("rst_done", 32'(b8.word_done), 0);
        check("rst_seg", 32'(b8.seg), 32'h3F);
        b8.nib_sel = 3'd2; #1;
        check("blank_seg", 32'(b8.seg), 32'h00);
        b8.nib_sel = 3'd0;

        // Load and display
        cyc(0, 1, 3'd5, 0, 8'hA5);
        check("load_q", 32'(b8.q), 32'hA5);
        check("load_seg0", 32'(b8.seg), 32'h6D);
        b8.nib_sel = 3'd1; #1;
        check("load_seg1", 32'(b8.seg), 32'h77);
        for (int i = 0; i < 3; i++) cyc(0, 1, 3'd0, 0, 8'h00);
        check("hold_q", 32'(b8.q), 32'hA5);
        b8.nib_sel = 3'd0;

        // Deserialize: bits 1,0,1,1,0,0,1,0 via SHR
        cyc(0, 1, 3'd6, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 3'd1, SER_SEQ[i], 8'h00);
            if (i == 6) check("des_done7", 32'(b8.word_done), 0);
        end
        check("des_q", 32'(b8.q), 32'h4D);
        check("des_done", 32'(b8.word_done), 1);
        check("des_cnt", 32'(b8.shift_cnt), 0);
        cyc(0, 1, 3'd1, 0, 8'h00);
        check("des9_cnt", 32'(b8.shift_cnt), 1);
        check("des9_done", 32'(b8.word_done), 0);

        // Rotate / arithmetic shift
        cyc(0, 1, 3'd5, 0, 8'h81);
        cyc(0, 1, 3'd4, 0, 8'h00);
        check("rol_q", 32'(b8.q), 32'h03);
        cyc(0, 1, 3'd3, 0, 8'h00);
        check("ror_q", 32'(b8.q), 32'h81);
        cyc(0, 1, 3'd7, 0, 8'h00);
        check("asr1_q", 32'(b8.q), 32'hC0);
        cyc(0, 1, 3'd7, 0, 8'h00);
        check("asr2_q", 32'(b8.q), 32'hE0);
        check("rot_cnt", 32'(b8.shift_cnt), 0);

        // Enable and reset priority
        cyc(0, 1, 3'd6, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 3'd2, 1, 8'h00);
        check("shl_q", 32'(b8.q), 32'h1F);
        check("shl_cnt", 32'(b8.shift_cnt), 5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 3'd2, 1, 8'h00);
        check("en0_q", 32'(b8.q), 32'h1F);
        check("en0_cnt", 32'(b8.shift_cnt), 5);
        cyc(1, 1, 3'd2, 1, 8'h00);
        check("rstp_q", 32'(b8.q), 32'h00);
        check("rstp_cnt", 32'(b8.shift_cnt), 0);
        check("rstp_done", 32'(b8.word_done), 0);

        // WIDTH=4: word_done after 4 shifts
        b8.mode = 3'd0; reset = 1'b0;
        b4.en = 1'b1; b4.mode = 3'd1; b4.ser_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) begin
                check("w4_cnt3", 32'(b4.shift_cnt), 3);
                check("w4_done3", 32'(b4.word_done), 0);
            end
        end
        check("w4_q", 32'(b4.q), 32'hF);
        check("w4_done", 32'(b4.word_done), 1);
        check("w4_cnt", 32'(b4.shift_cnt), 0);
        b4.en = 1'b0;

        // WIDTH=12: nibble display
        b12.en = 1'b1; b12.mode = 3'd5; b12.par_in = 12'hABC;
        tick();
        b12.en = 1'b0;
        check("w12_q", 32'(b12.q), 32'hABC);
        b12.nib_sel = 3'd0; #1; check("w12_seg0", 32'(b12.seg), 32'h39);
        b12.nib_sel = 3'd1; #1; check("w12_seg1", 32'(b12.seg), 32'h7C);
        b12.nib_sel = 3'd2; #1; check("w12_seg2", 32'(b12.seg), 32'h77);
        b12.nib_sel = 3'd3; #1; check("w12_seg3", 32'(b12.seg), 32'h00);

        // Randomized traffic against the model, biased toward serial modes
        for (int i = 0; i < 600; i++) begin
            logic       r, e, s;
            logic [2:0] m;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 7) != 0);
            m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) m = 3'($urandom_range(1, 2));
            s = 1'($urandom_range(0, 1));
            b8.nib_sel = 3'($urandom_range(0, 7));
            cyc(r, e, m, s, 8'($urandom));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
